// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master bridge and the completer register bank.
package apb_pkg;

  localparam int unsigned APB_ADDR_W    = 8;
  localparam int unsigned APB_DATA_W    = 8;
  localparam int unsigned APB_SLV_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x DATA_W register storage: asynchronous clear, one synchronous write port,
// one combinational read port (out-of-range read index returns zero).
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH  = APB_SLV_DEPTH,
  parameter int unsigned DATA_W = APB_DATA_W,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) rdata = mem[raddr];
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// Clocked APB completer: register bank with WAIT_CYCLES access-phase wait states.
// Optional macro APB_SLV_WLOCK_EN turns register DEPTH-1 into a write-lock register.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = APB_SLV_DEPTH,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  apb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;

  logic              setup, access;
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_write;
  logic [IDX_W-1:0]  eff_idx;
  logic              addr_err, lock_err, resp_err;
  logic [DATA_W-1:0] rf_rdata, resp_data;
  logic              commit, rf_we;

  assign setup  = PSEL && !PENABLE;
  assign access = PSEL && PENABLE;

  // With zero wait states RESP is entered on the setup edge itself, so the response
  // must be built from the live bus rather than the holding registers.
  assign eff_addr  = (state == IDLE) ? PADDR  : haddr;
  assign eff_write = (state == IDLE) ? PWRITE : hwrite;
  assign eff_idx   = eff_addr[IDX_W-1:0];
  assign addr_err  = (32'(eff_addr) >= DEPTH);
  assign commit    = (state == RESP) && access && hwrite && !PSLVERR;

`ifdef APB_SLV_WLOCK_EN
  logic lock_q;
  logic is_lock;

  assign is_lock  = !addr_err && (eff_idx == LAST_IDX);
  assign lock_err = eff_write && lock_q && !addr_err && !is_lock;
  assign rf_we    = commit && (haddr[IDX_W-1:0] != LAST_IDX);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                                     lock_q <= 1'b0;
    else if (commit && haddr[IDX_W-1:0] == LAST_IDX)  lock_q <= hwdata[0];
  end

  always_comb begin
    resp_data = '0;
    if (!eff_write && !resp_err) begin
      if (is_lock) resp_data = DATA_W'(lock_q);
      else         resp_data = rf_rdata;
    end
  end
`else
  assign lock_err = 1'b0;
  assign rf_we    = commit;

  always_comb begin
    resp_data = '0;
    if (!eff_write && !resp_err) resp_data = rf_rdata;
  end
`endif

  assign resp_err = addr_err || lock_err;

  apb_slv_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (rf_we),
    .waddr (haddr[IDX_W-1:0]),
    .wdata (hwdata),
    .raddr (eff_idx),
    .rdata (rf_rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      haddr   <= '0;
      hwrite  <= 1'b0;
      hwdata  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            haddr  <= PADDR;
            hwrite <= PWRITE;
            hwdata <= PWDATA;
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= resp_err;
              PRDATA  <= resp_data;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (PENABLE) begin
            if (cnt == CNT_W'(1)) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= resp_err;
              PRDATA  <= resp_data;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        RESP: begin
          state   <= IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: one completer with 2 wait states, one with none, on a shared bus.
module tb_apb_slave_regbank;
  import apb_pkg::*;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       psel, penable, pwrite, use_fast;
  logic [7:0] paddr, pwdata;
  logic [7:0] s_rdata, f_rdata;
  logic       s_ready, f_ready, s_err, f_err;
  logic       rdy, perr;
  logic [7:0] prdata;

  int nvec = 0;
  int nmis = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_regbank #(.WAIT_CYCLES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel && !use_fast), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(s_rdata), .PREADY(s_ready), .PSLVERR(s_err)
  );

  apb_slave_regbank #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel && use_fast), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(f_rdata), .PREADY(f_ready), .PSLVERR(f_err)
  );

  assign rdy    = use_fast ? f_ready : s_ready;
  assign perr   = use_fast ? f_err   : s_err;
  assign prdata = use_fast ? f_rdata : s_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One transfer from setup to the cycle PREADY is seen; n is the access cycle
  // index (T1 = 1) in which PREADY was high, 0 on timeout.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                      input logic scr, output logic [7:0] rd, output logic err,
                      output int n);
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    n = 0; rd = '0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge PCLK);
      if (i == 1) begin
        penable = 1'b1;
        if (scr) begin paddr = ~a; pwdata = ~d; end
      end
      if (rdy) begin n = i; rd = prdata; err = perr; break; end
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] a, input logic [7:0] d,
                        input logic exp_err);
    logic [7:0] rd; logic err; int n;
    xfer(1'b1, a, d, 1'b0, rd, err, n);
    chk({tag, "_lat"}, n, use_fast ? 1 : 3);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_rdata"}, rd, 0);
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp_d,
                        input logic exp_err);
    logic [7:0] rd; logic err; int n;
    xfer(1'b0, a, 8'h00, 1'b0, rd, err, n);
    chk({tag, "_lat"}, n, use_fast ? 1 : 3);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_data"}, rd, exp_d);
    idle();
  endtask

  logic [7:0] rd;
  logic       err;
  int         n;

  initial begin
    PRESETn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; use_fast = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rst_ready", s_ready, 0);
    chk("rst_err", s_err, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_ready_fast", f_ready, 0);
    PRESETn = 1'b1;

    wr_chk("wr_10", 8'h10, 8'h5A, 1'b0);
    rd_chk("rd_10", 8'h10, 8'h5A, 1'b0);

    // Out of range: no wrap-around onto low registers
    wr_chk("wr_40", 8'h40, 8'hFF, 1'b1);
    rd_chk("rd_40", 8'h40, 8'h00, 1'b1);
    rd_chk("rd_ff", 8'hFF, 8'h00, 1'b1);
    rd_chk("rd_00", 8'h00, 8'h00, 1'b0);

    // Address/data changing during access must not matter
    xfer(1'b1, 8'h20, 8'h3C, 1'b1, rd, err, n);
    chk("scr_lat", n, 3);
    chk("scr_err", err, 0);
    idle();
    rd_chk("rd_20", 8'h20, 8'h3C, 1'b0);
    rd_chk("rd_df", 8'hDF, 8'h00, 1'b1);

    // Access phase without a setup phase is ignored
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'h66;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("noset_ready", s_ready, 0);
    end
    idle();
    rd_chk("rd_06", 8'h06, 8'h00, 1'b0);

    // Abort: PSEL dropped in T1
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'hAA;
    @(negedge PCLK);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("abort_ready", s_ready, 0);
    end
    rd_chk("rd_05", 8'h05, 8'h00, 1'b0);

`ifdef APB_SLV_WLOCK_EN
    wr_chk("lock_on", 8'h3F, 8'h01, 1'b0);
    rd_chk("rd_lock", 8'h3F, 8'h01, 1'b0);
    wr_chk("wr_02_lk", 8'h02, 8'h77, 1'b1);
    rd_chk("rd_02_lk", 8'h02, 8'h00, 1'b0);
    wr_chk("lock_ff", 8'h3F, 8'hFF, 1'b0);
    rd_chk("rd_lock_ff", 8'h3F, 8'h01, 1'b0);
    wr_chk("lock_off", 8'h3F, 8'h00, 1'b0);
    wr_chk("wr_02", 8'h02, 8'h77, 1'b0);
    rd_chk("rd_02", 8'h02, 8'h77, 1'b0);
`else
    wr_chk("wr_3f", 8'h3F, 8'hA5, 1'b0);
    wr_chk("wr_02", 8'h02, 8'h77, 1'b0);
    rd_chk("rd_3f", 8'h3F, 8'hA5, 1'b0);
    rd_chk("rd_02", 8'h02, 8'h77, 1'b0);
`endif

    // Zero wait states, back-to-back
    use_fast = 1'b1;
    xfer(1'b1, 8'h01, 8'h11, 1'b0, rd, err, n);
    chk("f_wr_lat", n, 1);
    chk("f_wr_err", err, 0);
    xfer(1'b0, 8'h01, 8'h00, 1'b0, rd, err, n);
    chk("f_rd_lat", n, 1);
    chk("f_rd_data", rd, 8'h11);
    xfer(1'b1, 8'h50, 8'h22, 1'b0, rd, err, n);
    chk("f_oor_err", err, 1);
    idle();
    rd_chk("f_rd_10", 8'h10, 8'h00, 1'b0);
    use_fast = 1'b0;

    // Reset while PREADY is high clears outputs immediately and the memory
    xfer(1'b0, 8'h20, 8'h00, 1'b0, rd, err, n);
    chk("pre_rst_data", rd, 8'h3C);
    PRESETn = 1'b0;
    #1;
    chk("rstr_ready", s_ready, 0);
    chk("rstr_rdata", s_rdata, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd_chk("rd_20_rst", 8'h20, 8'h00, 1'b0);
    rd_chk("rd_10_rst", 8'h10, 8'h00, 1'b0);

    // Reset during WAIT of a write
    @(negedge PCLK);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'h33;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("rstw_ready", s_ready, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    rd_chk("rd_07", 8'h07, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
